// File: rtl/rot_pkg.sv
// Shared types and default sizing for the rotation frame sequencer.
package rot_pkg;
    localparam int POINT_WIDTH = 12;
    localparam int MAX_POINTS  = 32;
    localparam int IDX_W       = $clog2(MAX_POINTS + 1);
    localparam int FIFO_DEPTH  = 8;

    // Element [0] is x, [1] is y, [2] is z; each element is a signed coordinate.
    typedef logic signed [2:0][POINT_WIDTH-1:0] point_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } seq_state_e;
endpackage

// File: rtl/rotation_sequencer_if.sv
// Rotated-point stream from the sequencer to the projection stage.
interface rotation_sequencer_if
    import rot_pkg::*;
#(
    parameter int IDX_W = rot_pkg::IDX_W
);
    logic             pt_valid;
    point_t           pt_data;
    logic [IDX_W-1:0] pt_idx;
    logic             pt_last;
    logic             pt_ready;

    modport master (output pt_valid, output pt_data, output pt_idx, output pt_last, input pt_ready);
    modport slave  (input pt_valid, input pt_data, input pt_idx, input pt_last, output pt_ready);
endinterface

// File: rtl/rot_fifo.sv
// First-word-fall-through point FIFO; the head entry is visible whenever not empty.
module rot_fifo
    import rot_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  point_t           i_data,
    input  logic             i_pop,
    output point_t           o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    point_t           r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage needs no reset: the head is never consumed while empty.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CNT_W'(0);
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == CNT_W'(0));
endmodule

// File: rtl/rotation_sequencer.sv
// Frame controller: walks vertex memory into the rotation datapath under a credit
// limit and streams the rotated points out through a FIFO.
module rotation_sequencer
    import rot_pkg::*;
#(
    parameter int MAX_POINTS = rot_pkg::MAX_POINTS,
    parameter int FIFO_DEPTH = rot_pkg::FIFO_DEPTH,
    parameter int IDX_W      = $clog2(MAX_POINTS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_frame_start,
    input  logic [IDX_W-1:0]            i_num_points,
    input  point_t                      i_sin_cfg,
    input  point_t                      i_cos_cfg,
    output logic                        o_busy,
    output logic                        o_frame_done,
    output logic                        o_err,
    output logic                        o_vtx_rd_en,
    output logic [IDX_W-1:0]            o_vtx_addr,
    input  point_t                      i_vtx_data,
    output logic                        o_rot_valid_in,
    output point_t                      o_rot_in,
    output point_t                      o_rot_sin,
    output point_t                      o_rot_cos,
    input  logic                        i_rot_valid_out,
    input  point_t                      i_rot_out,
    rotation_sequencer_if.master        o_pt
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    seq_state_e       r_state, w_next;
    logic [IDX_W-1:0] r_num, r_issued, r_popped;
    point_t           r_sin, r_cos;
    logic [CNT_W-1:0] r_in_flight;
    logic             r_err, r_busy, r_frame_done, r_rot_valid_in;
    logic             w_start, w_rd_en, w_done, w_pop, w_push, w_credit_ok;
    logic             w_full, w_empty;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_occupancy;
    point_t           w_head;

    // Results already queued plus results still inside the rotation pipe must fit.
    assign w_occupancy = {1'b0, w_count} + {1'b0, r_in_flight};
    assign w_credit_ok = (w_occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign w_pop       = !w_empty && o_pt.pt_ready;
    assign w_push      = i_rot_valid_out && (r_in_flight != CNT_W'(0)) && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_rd_en = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_frame_start && !r_frame_done) begin
                    w_start = 1'b1;
                    w_next  = (i_num_points == IDX_W'(0)) ? S_DRAIN : S_ISSUE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (w_credit_ok && (r_issued < r_num)) begin
                    w_rd_en = 1'b1;
                    w_next  = (r_issued + IDX_W'(1) == r_num) ? S_DRAIN : S_ISSUE;
                end else begin
                    w_next = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if ((r_num == IDX_W'(0)) || (w_pop && (r_popped + IDX_W'(1) == r_num))) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num          <= IDX_W'(0);
            r_sin          <= point_t'(0);
            r_cos          <= point_t'(0);
            r_issued       <= IDX_W'(0);
            r_popped       <= IDX_W'(0);
            r_in_flight    <= CNT_W'(0);
            r_err          <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
            r_rot_valid_in <= 1'b0;
        end else begin
            if (w_start) begin
                r_num    <= i_num_points;
                r_sin    <= i_sin_cfg;
                r_cos    <= i_cos_cfg;
                r_issued <= IDX_W'(0);
                r_popped <= IDX_W'(0);
            end else begin
                r_issued <= w_rd_en ? r_issued + IDX_W'(1) : r_issued;
                r_popped <= w_pop ? r_popped + IDX_W'(1) : r_popped;
            end
            case ({w_rd_en, i_rot_valid_out && (r_in_flight != CNT_W'(0))})
                2'b10:   r_in_flight <= r_in_flight + CNT_W'(1);
                2'b01:   r_in_flight <= r_in_flight - CNT_W'(1);
                default: r_in_flight <= r_in_flight;
            endcase
            // A result with no outstanding credit is dropped and flagged until reset.
            r_err          <= r_err || (i_rot_valid_out && (r_in_flight == CNT_W'(0)));
            r_busy         <= (w_next != S_IDLE);
            r_frame_done   <= w_done;
            r_rot_valid_in <= w_rd_en;
        end
    end

    rot_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (i_rot_out),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_busy         = r_busy;
    assign o_frame_done   = r_frame_done;
    assign o_err          = r_err;
    assign o_vtx_rd_en    = w_rd_en;
    assign o_vtx_addr     = w_rd_en ? r_issued : IDX_W'(0);
    assign o_rot_valid_in = r_rot_valid_in;
    assign o_rot_in       = r_rot_valid_in ? i_vtx_data : point_t'(0);
    assign o_rot_sin      = r_sin;
    assign o_rot_cos      = r_cos;

    assign o_pt.pt_valid  = !w_empty;
    assign o_pt.pt_data   = w_empty ? point_t'(0) : w_head;
    assign o_pt.pt_idx    = r_popped;
    assign o_pt.pt_last   = !w_empty && (r_popped == r_num - IDX_W'(1));
endmodule

// File: tb/tb_rotation_sequencer.sv
// Directed bench for rotation_sequencer with a vertex memory and a two-stage rotation stand-in.
module tb_rotation_sequencer;
    import rot_pkg::*;

    localparam int W  = POINT_WIDTH;
    localparam int IW = rot_pkg::IDX_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic [IW-1:0] num_points = '0;
    point_t        sin_cfg = '0;
    point_t        cos_cfg = '0;
    logic          busy, frame_done, err, vtx_rd_en, rot_valid_in, rot_valid_out;
    logic [IW-1:0] vtx_addr;
    point_t        vtx_data, rot_in, rot_sin, rot_cos, rot_out;
    logic          inj_v = 1'b0;
    point_t        inj_d = '0;
    logic          s1_v = 1'b0, s2_v = 1'b0;
    point_t        s1_d, s2_d;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int     rd_addr_q[$];
    int     rd_cyc_q[$];
    int     pop_idx_q[$];
    logic   pop_last_q[$];
    point_t pop_data_q[$];
    int     rvi_cnt = 0, pv_cnt = 0, done_cnt = 0, done_cyc = 0, last_pop_cyc = 0;

    rotation_sequencer_if pt_if ();

    rotation_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .i_frame_start   (frame_start),
        .i_num_points    (num_points),
        .i_sin_cfg       (sin_cfg),
        .i_cos_cfg       (cos_cfg),
        .o_busy          (busy),
        .o_frame_done    (frame_done),
        .o_err           (err),
        .o_vtx_rd_en     (vtx_rd_en),
        .o_vtx_addr      (vtx_addr),
        .i_vtx_data      (vtx_data),
        .o_rot_valid_in  (rot_valid_in),
        .o_rot_in        (rot_in),
        .o_rot_sin       (rot_sin),
        .o_rot_cos       (rot_cos),
        .i_rot_valid_out (rot_valid_out),
        .i_rot_out       (rot_out),
        .o_pt            (pt_if)
    );

    always #5 clk = ~clk;

    function automatic point_t mk(input int x, input int y, input int z);
        point_t p;
        p[0] = W'(x);
        p[1] = W'(y);
        p[2] = W'(z);
        return p;
    endfunction

    function automatic point_t vtx(input int i);
        return mk(i * 53 - 400, 300 - i * 29, ((i % 2) == 1) ? 1000 - i : i - 1000);
    endfunction

    // Stand-in for the rotation datapath: per-axis v*cos/2048 + sin/256.
    function automatic point_t rot_f(input point_t v, input point_t s, input point_t c);
        point_t r;
        logic signed [2*W-1:0] prod;
        logic signed [2*W-1:0] sum;
        for (int k = 0; k < 3; k++) begin
            prod = $signed(v[k]) * $signed(c[k]);
            sum  = (prod >>> 11) + ($signed(s[k]) >>> 8);
            r[k] = sum[W-1:0];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (vtx_rd_en) vtx_data <= vtx(int'(vtx_addr));
        s1_v <= rot_valid_in;
        s1_d <= rot_f(rot_in, rot_sin, rot_cos);
        s2_v <= s1_v;
        s2_d <= s1_d;
    end

    assign rot_valid_out = s2_v | inj_v;
    assign rot_out       = inj_v ? inj_d : s2_d;

    always @(negedge clk) begin
        if (vtx_rd_en) begin
            rd_addr_q.push_back(int'(vtx_addr));
            rd_cyc_q.push_back(cyc);
        end
        if (rot_valid_in) rvi_cnt++;
        if (pt_if.pt_valid) pv_cnt++;
        if (pt_if.pt_valid && pt_if.pt_ready) begin
            pop_idx_q.push_back(int'(pt_if.pt_idx));
            pop_last_q.push_back(pt_if.pt_last);
            pop_data_q.push_back(pt_if.pt_data);
            last_pop_cyc = cyc;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        d0 = done_cnt;
        for (int n = 0; n < budget && done_cnt == d0; n++) tick();
        chk(tag, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Compares pops [base, base+n) against the index order and reference data.
    task automatic chk_frame(input string tag, input int base, input int n, input point_t s, input point_t c);
        int bad;
        int lasts;
        bad   = 0;
        lasts = 0;
        chk({tag, "_pops"}, 64'(pop_idx_q.size() - base), 64'(n));
        for (int i = 0; i < n && base + i < pop_idx_q.size(); i++) begin
            if (pop_idx_q[base + i] != i) bad++;
            if (pop_data_q[base + i] !== rot_f(vtx(i), s, c)) bad++;
            if (pop_last_q[base + i]) lasts++;
        end
        chk({tag, "_seq_bad"}, 64'(bad), 64'd0);
        chk({tag, "_last_cnt"}, 64'(lasts), 64'd1);
        if (pop_idx_q.size() >= base + n && n > 0) begin
            chk({tag, "_last_pos"}, 64'(pop_last_q[base + n - 1]), 64'd1);
        end
    endtask

    initial begin
        int b_rd, b_pop, b_rvi, b_pv, t0;
        point_t sa, ca, sb, cb;

        pt_if.pt_ready = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rd_en", 64'(vtx_rd_en), 64'd0);
        chk("rst_rvi", 64'(rot_valid_in), 64'd0);
        chk("rst_pt_valid", 64'(pt_if.pt_valid), 64'd0);
        chk("rst_rot_sin", 64'(rot_sin), 64'd0);
        rst = 1'b0;
        tick();

        // Cube frame with free-running downstream
        sa = mk(2044, 2044, 2044);
        ca = mk(128, -128, 128);
        sin_cfg = sa; cos_cfg = ca; num_points = IW'(8); pt_if.pt_ready = 1'b1;
        b_rd = rd_addr_q.size(); b_pop = pop_idx_q.size();
        pulse_start();
        chk("cube_busy", 64'(busy), 64'd1);
        wait_done(200, "cube_done");
        chk("cube_reads", 64'(rd_addr_q.size() - b_rd), 64'd8);
        for (int i = 0; i < 8 && b_rd + i < rd_addr_q.size(); i++)
            chk($sformatf("cube_addr%0d", i), 64'(rd_addr_q[b_rd + i]), 64'(i));
        if (rd_addr_q.size() >= b_rd + 8)
            chk("cube_consec", 64'(rd_cyc_q[b_rd + 7] - rd_cyc_q[b_rd]), 64'd7);
        chk_frame("cube", b_pop, 8, sa, ca);
        chk("cube_done_lat", 64'(done_cyc - last_pop_cyc), 64'd1);
        chk("cube_busy_end", 64'(busy), 64'd0);
        tick();

        // Empty frame
        num_points = IW'(0);
        b_rd = rd_addr_q.size(); b_rvi = rvi_cnt; b_pv = pv_cnt;
        t0 = cyc;
        pulse_start();
        wait_done(20, "zero_done");
        chk("zero_done_lat", 64'(done_cyc - t0), 64'd2);
        chk("zero_reads", 64'(rd_addr_q.size() - b_rd), 64'd0);
        chk("zero_rvi", 64'(rvi_cnt - b_rvi), 64'd0);
        chk("zero_pv", 64'(pv_cnt - b_pv), 64'd0);
        tick();

        // Backpressure: credits stop issue at FIFO depth
        num_points = IW'(20); pt_if.pt_ready = 1'b0;
        b_rd = rd_addr_q.size(); b_pop = pop_idx_q.size();
        pulse_start();
        repeat (30) tick();
        chk("bp_reads", 64'(rd_addr_q.size() - b_rd), 64'd8);
        chk("bp_valid", 64'(pt_if.pt_valid), 64'd1);
        chk("bp_idx_hold", 64'(pt_if.pt_idx), 64'd0);
        chk("bp_data_hold", 64'(pt_if.pt_data), 64'(rot_f(vtx(0), sa, ca)));
        pt_if.pt_ready = 1'b1;
        tick();
        pt_if.pt_ready = 1'b0;
        repeat (10) tick();
        chk("bp_one_more", 64'(rd_addr_q.size() - b_rd), 64'd9);
        chk("bp_one_pop", 64'(pop_idx_q.size() - b_pop), 64'd1);
        chk("bp_idx_next", 64'(pt_if.pt_idx), 64'd1);
        chk("bp_err", 64'(err), 64'd0);
        pt_if.pt_ready = 1'b1;
        wait_done(300, "bp_done");
        chk_frame("bp", b_pop, 20, sa, ca);
        chk("bp_err_end", 64'(err), 64'd0);
        tick();

        // Reconfiguration attempt while busy is ignored
        sb = mk(1000, -500, 300);
        cb = mk(-2000, 1500, 700);
        sin_cfg = sb; cos_cfg = cb; num_points = IW'(12);
        b_pop = pop_idx_q.size();
        pulse_start();
        repeat (3) tick();
        sin_cfg = mk(5, 5, 5); cos_cfg = mk(9, 9, 9); num_points = IW'(3);
        pulse_start();
        chk("mid_rot_sin", 64'(rot_sin), 64'(sb));
        chk("mid_rot_cos", 64'(rot_cos), 64'(cb));
        chk("mid_busy", 64'(busy), 64'd1);
        wait_done(200, "mid_done");
        chk_frame("mid", b_pop, 12, sb, cb);
        tick();

        // Asynchronous reset on the 4th pop
        sin_cfg = sa; cos_cfg = ca; num_points = IW'(20);
        b_pop = pop_idx_q.size();
        pulse_start();
        for (int n = 0; n < 100; n++) begin
            if (pop_idx_q.size() - b_pop == 3 && pt_if.pt_valid) break;
            tick();
        end
        chk("rst4_reach", 64'(pop_idx_q.size() - b_pop), 64'd3);
        rst = 1'b1;
        #1;
        chk("rst4_busy", 64'(busy), 64'd0);
        chk("rst4_pt_valid", 64'(pt_if.pt_valid), 64'd0);
        chk("rst4_pt_data", 64'(pt_if.pt_data), 64'd0);
        chk("rst4_pt_idx", 64'(pt_if.pt_idx), 64'd0);
        chk("rst4_pt_last", 64'(pt_if.pt_last), 64'd0);
        chk("rst4_rd_en", 64'(vtx_rd_en), 64'd0);
        chk("rst4_rvi", 64'(rot_valid_in), 64'd0);
        chk("rst4_rot_in", 64'(rot_in), 64'd0);
        chk("rst4_rot_cos", 64'(rot_cos), 64'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst4_pop_stop", 64'(pop_idx_q.size() - b_pop), 64'd3);
        num_points = IW'(5);
        b_rd = rd_addr_q.size(); b_pop = pop_idx_q.size();
        pulse_start();
        wait_done(100, "restart_done");
        if (rd_addr_q.size() > b_rd)
            chk("restart_addr0", 64'(rd_addr_q[b_rd]), 64'd0);
        chk("restart_reads", 64'(rd_addr_q.size() - b_rd), 64'd5);
        chk_frame("restart", b_pop, 5, sa, ca);
        chk("restart_err", 64'(err), 64'd0);
        tick();

        // Result with no credit outstanding
        b_pv = pv_cnt;
        inj_d = mk(1, 2, 3);
        inj_v = 1'b1;
        tick();
        inj_v = 1'b0;
        chk("inj_err", 64'(err), 64'd1);
        chk("inj_no_write", 64'(pt_if.pt_valid), 64'd0);
        repeat (5) tick();
        chk("inj_err_sticky", 64'(err), 64'd1);
        chk("inj_pv_none", 64'(pv_cnt - b_pv), 64'd0);
        rst = 1'b1;
        tick();
        chk("inj_err_clear", 64'(err), 64'd0);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rotation_sequencer.md
Name: rotation_sequencer

Overview:
Frame-level controller for the `rotation` datapath. On each frame start it latches one set of sin/cos angles and walks a vertex memory from index 0 to num_points-1, issuing each vertex to `rotation`. It collects the rotated points in an internal FIFO and presents them to the downstream projection stage over a valid/ready handshake. Because `rotation` has no backpressure, issue is credit-limited so that the FIFO can never overflow.

Parameters:
POINT_WIDTH, 12, signed coordinate and sin/cos width (matches `rotation`)
MAX_POINTS, 32, maximum vertices per frame
IDX_W, $clog2(MAX_POINTS+1), width of index and count fields
FIFO_DEPTH, 8, output FIFO entries; power of 2, at least 2

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
frame_start  in  1  pulse; starts a frame when idle
num_points  in  IDX_W  vertex count, sampled with frame_start; 0 to MAX_POINTS
sin_cfg  in  3 x POINT_WIDTH signed  per-axis sine, sampled with frame_start
cos_cfg  in  3 x POINT_WIDTH signed  per-axis cosine, sampled with frame_start
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at end of frame
err  out  1  sticky; rot_valid_out arrived with no credit outstanding
vtx_rd_en  out  1  vertex memory read strobe
vtx_addr  out  IDX_W  vertex memory address
vtx_data  in  3 x POINT_WIDTH signed  vertex; valid exactly 1 cycle after vtx_rd_en
rot_valid_in  out  1  to rotation valid_in
rot_in  out  3 x POINT_WIDTH signed  to rotation rot_in
rot_sin  out  3 x POINT_WIDTH signed  to rotation sin
rot_cos  out  3 x POINT_WIDTH signed  to rotation cos
rot_valid_out  in  1  from rotation valid_out
rot_out  in  3 x POINT_WIDTH signed  from rotation rot_out
pt_valid  out  1  rotated point available
pt_data  out  3 x POINT_WIDTH signed  rotated point
pt_idx  out  IDX_W  vertex index of pt_data
pt_last  out  1  pt_data is the final vertex of the frame
pt_ready  in  1  downstream accepts the point

Behaviour:
- Reset (async, any time, including mid-frame): state IDLE.
  - All outputs 0; FIFO emptied; counters cleared; err cleared.
  - In-flight rotation results arriving after reset deassertion set err.
- FSM: IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE:
  - frame_start=1 latches num_points, sin_cfg and cos_cfg into shadow registers, then goes to ISSUE; busy=1 from the next cycle.
  - If num_points=0: go directly to DRAIN; no reads are issued.
- frame_start while busy is ignored. Shadow registers are unchanged, so rot_sin/rot_cos are constant for the whole frame.
- rot_sin/rot_cos are driven from the shadow registers at all times.
- ISSUE:
  - Read when issued < num_points and (fifo_count + in_flight) < FIFO_DEPTH.
  - A read asserts vtx_rd_en with vtx_addr = issued; issued increments.
  - After a maximum of one read per cycle, once issued = num_points, go to DRAIN.
- Issue path timing:
  - rot_valid_in is vtx_rd_en delayed 1 cycle.
  - rot_in = vtx_data, passed combinationally with no extra register. Issue-to-rotation latency is 1 cycle.
- in_flight:
  - +1 on vtx_rd_en, -1 on rot_valid_out; both in the same cycle gives no change.
  - rot_valid_out with in_flight=0 sets err; the data is dropped.
- FIFO:
  - Write on rot_valid_out; pop when pt_valid and pt_ready.
  - Simultaneous push and pop allowed at full or empty (first-word-fall-through, so an empty FIFO pushes then pops the next cycle).
  - The credit rule guarantees no overflow.
- Output:
  - pt_valid = FIFO not empty; pt_data = FIFO head.
  - pt_idx = pop counter (results are in order).
  - pt_last = (pt_idx == num_points-1).
  - pt_data, pt_idx and pt_last are stable while pt_valid and not pt_ready.
- DRAIN: when popped = num_points (or num_points=0), pulse frame_done for 1 cycle, drop busy and return to IDLE. frame_done asserts the cycle after the final pop handshake.
- A new frame_start is accepted in the cycle after frame_done.

Decomposition:
- Package rot_pkg:
  - POINT_WIDTH default.
  - typedef point_t: logic signed [POINT_WIDTH-1:0] [3].
  - typedef seq_state_e.
- Sub-module rot_fifo: parameterised synchronous FIFO, first-word-fall-through, with count, full and empty outputs.

Test Plan:
- Cube frame, num_points=8, sin={2044,2044,2044}, cos={128,-128,128}, pt_ready=1:
  - 8 vtx_rd_en on addr 0..7 in consecutive cycles.
  - 8 pt beats with pt_idx 0..7; pt_last only on idx 7.
  - Data matches the reference model; frame_done 1 cycle after the last pop.
- Backpressure, num_points=20, FIFO_DEPTH=8, pt_ready=0:
  - Exactly 8 reads are issued, then vtx_rd_en stays 0.
  - Raising pt_ready for one pop allows exactly one new read; err stays 0.
- num_points=0: frame_done 2 cycles after frame_start; no vtx_rd_en, pt_valid or rot_valid_in.
- Change sin_cfg/cos_cfg and pulse frame_start mid-frame:
  - rot_sin/rot_cos and the frame count are unchanged.
  - The frame completes normally.
- Assert rst at the 4th pop of a 20-point frame:
  - All outputs 0 immediately, busy=0.
  - The next frame_start restarts at addr 0.
- Inject rot_valid_out with no reads outstanding: err=1, sticky until rst; no FIFO write.
